// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC and issues one instruction-memory
// request at a time. It delivers {valid, instr, pc} to decode through the IF/ID
// register. Decode stalls are absorbed by a one-entry hold buffer. Responses
// orphaned by a flush are dropped in the DROP state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_next,
  output logic        pc_advance,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;

  logic        w_req_valid;
  logic        w_accept;
  logic        w_deliver;
  logic        w_from_hold;
  logic        w_load_hold;

  // Request handshake, next-state selection and IF/ID / hold-buffer load controls.
  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_from_hold = 1'b0;
    w_load_hold = 1'b0;
    // Request is a decode of the state register. It is gated by rst_n so that it stays low while reset is held.
    if (r_state == S_REQ) begin
      w_req_valid = rst_n;
    end else begin
      w_req_valid = 1'b0;
    end
    w_accept = w_req_valid & imem_req_ready;
    if (flush) begin
      // A redirect leaves behind only a possibly outstanding response. That response must be swallowed.
      case (r_state)
        S_REQ:   w_state_nxt = w_accept ? S_DROP : S_REQ;
        S_WAIT:  w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DROP:  w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (id_stall) begin
              w_load_hold = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_deliver   = 1'b1;
              w_state_nxt = S_REQ;
            end
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            w_deliver   = 1'b1;
            w_from_hold = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        S_DROP: w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  assign pc_advance     = w_accept & ~flush;
  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  assign pc_o           = r_pc;
  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC: a redirect wins over a normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (flush) begin
      r_pc <= flush_pc;
    end else if (pc_advance) begin
      r_pc <= pc_next;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Remember the address of the request in flight so that its response can be tagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_pc <= 32'h0000_0000;
    end else if (pc_advance) begin
      r_req_pc <= r_pc;
    end else begin
      r_req_pc <= r_req_pc;
    end
  end

  // Hold buffer: parks a response that arrived while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
    end else if (w_load_hold) begin
      r_hold_instr <= imem_rdata;
      r_hold_pc    <= r_req_pc;
    end else begin
      r_hold_instr <= r_hold_instr;
      r_hold_pc    <= r_hold_pc;
    end
  end

  // IF/ID register: flush kills, delivery loads, stall holds, otherwise bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= 32'h0000_0000;
      r_id_pc    <= 32'h0000_0000;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (w_deliver) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_from_hold ? r_hold_instr : imem_rdata;
      r_id_pc    <= w_from_hold ? r_hold_pc : r_req_pc;
    end else if (!id_stall) begin
      r_id_valid <= 1'b0;
    end else begin
      r_id_valid <= r_id_valid;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. The directed scenarios use constant expectations.
// The random scenario is checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] pc_next;
  logic        pc_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .pc_next(pc_next), .pc_advance(pc_advance),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .flush(flush), .flush_pc(flush_pc), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, kept in transaction terms:
  // m_pend  - a request is in flight.
  // m_stale - the in-flight request's answer must be discarded.
  // m_held  - an answer is parked waiting for decode.
  bit          m_rst;
  bit          m_pend;
  bit          m_stale;
  bit          m_held;
  bit          m_idv;
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  logic [31:0] m_hold_i;
  logic [31:0] m_hold_p;
  logic [31:0] m_idi;
  logic [31:0] m_idp;

  function automatic bit m_req_valid();
    return !m_rst && !m_pend && !m_held;
  endfunction

  task automatic model_reset();
    m_rst = 1'b1; m_pend = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_idv = 1'b0;
    m_pc = 32'h0000_3000; m_req_addr = 32'h0; m_hold_i = 32'h0; m_hold_p = 32'h0;
    m_idi = 32'h0; m_idp = 32'h0;
  endtask

  task automatic model_edge();
    bit acc;
    bit dlv;
    logic [31:0] di;
    logic [31:0] dp;
    if (m_rst) return;
    acc = m_req_valid() && imem_req_ready;
    dlv = 1'b0; di = 32'h0; dp = 32'h0;
    if (flush) begin
      m_pc = flush_pc; m_idv = 1'b0; m_held = 1'b0;
      if (m_pend) begin
        if (imem_resp_valid) begin m_pend = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end else if (acc) begin
        m_pend = 1'b1; m_stale = 1'b1;
      end
    end else begin
      if (m_held && !id_stall) begin dlv = 1'b1; di = m_hold_i; dp = m_hold_p; m_held = 1'b0; end
      if (m_pend && imem_resp_valid) begin
        m_pend = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (id_stall) begin m_held = 1'b1; m_hold_i = imem_rdata; m_hold_p = m_req_addr; end
        else begin dlv = 1'b1; di = imem_rdata; dp = m_req_addr; end
      end
      if (acc) begin m_pend = 1'b1; m_stale = 1'b0; m_req_addr = m_pc; m_pc = pc_next; end
      if (dlv) begin m_idv = 1'b1; m_idi = di; m_idp = dp; end
      else if (!id_stall) m_idv = 1'b0;
    end
  endtask

  // One clock edge: the model follows the same inputs, and the outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic st, input logic fl, input logic [31:0] fpc,
                        input logic [31:0] pcn);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_rdata = rd;
    id_stall = st; flush = fl; flush_pc = fpc; pc_next = pcn;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1; m_rst = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1; #1 rst_n = 1'b0; model_reset(); #1;
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %h want 0", imem_req_valid); else n_pass++;
    n_checks++; if (pc_o !== 32'h0000_3000) $display("FAIL reset_pc got %h want 00003000", pc_o); else n_pass++;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %h want 0", id_valid); else n_pass++;
    n_checks++; if (id_instr !== 32'h0 || id_pc !== 32'h0) $display("FAIL reset_id got %h/%h want 0/0", id_instr, id_pc); else n_pass++;
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_held_req_valid got %h want 0", imem_req_valid); else n_pass++;
    rst_n = 1'b1; m_rst = 1'b0; #1;
    n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL release_req_valid got %h want 1", imem_req_valid); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, m_pc + 32'd4);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h3000 + 32'(4 * i))
        $display("FAIL stream_req[%0d] got %h/%h want 1/%h", i, imem_req_valid, imem_addr, 32'h3000 + 32'(4 * i)); else n_pass++;
      n_checks++; if (pc_advance !== 1'b1) $display("FAIL stream_adv_on[%0d] got %h want 1", i, pc_advance); else n_pass++;
      tick();
      n_checks++; if (id_valid !== 1'b0) $display("FAIL stream_bubble[%0d] got %h want 0", i, id_valid); else n_pass++;
      d = $urandom;
      set_in(1'b1, 1'b1, d, 1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++; if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0)
        $display("FAIL stream_wait[%0d] got %h/%h want 0/0", i, imem_req_valid, pc_advance); else n_pass++;
      tick();
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3000 + 32'(4 * i) || id_instr !== d)
        $display("FAIL stream_deliver[%0d] got %h/%h/%h want 1/%h/%h", i, id_valid, id_pc, id_instr, 32'h3000 + 32'(4 * i), d); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3004);
    tick();
    set_in(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h3008);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h3004 || pc_o !== 32'h3004 || pc_advance !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%h a=%h pc=%h adv=%h want 1/3004/3004/0", i, imem_req_valid, imem_addr, pc_o, pc_advance); else n_pass++;
      tick();
    end
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h3008);
    n_checks++; if (pc_advance !== 1'b1) $display("FAIL bp_accept_adv got %h want 1", pc_advance); else n_pass++;
    tick();
    n_checks++; if (pc_o !== 32'h3008 || imem_req_valid !== 1'b0) $display("FAIL bp_after got pc=%h v=%h want 3008/0", pc_o, imem_req_valid); else n_pass++;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3000) $display("FAIL bp_id_held got %h/%h want 1/3000", id_valid, id_pc); else n_pass++;
  endtask

  task automatic test_flush_wait();
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4180, 32'h5000);
    n_checks++; if (pc_advance !== 1'b0) $display("FAIL fw_adv got %h want 0", pc_advance); else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b0 || pc_o !== 32'h4180 || imem_req_valid !== 1'b0)
      $display("FAIL fw_after got v=%h pc=%h req=%h want 0/4180/0", id_valid, pc_o, imem_req_valid); else n_pass++;
    set_in(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h4184);
    tick();
    n_checks++; if (id_valid !== 1'b0) $display("FAIL fw_stale_dropped got %h want 0", id_valid); else n_pass++;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4180) $display("FAIL fw_next_req got %h/%h want 1/4180", imem_req_valid, imem_addr); else n_pass++;
  endtask

  task automatic test_hold();
    logic [31:0] r1;
    r1 = $urandom;
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4184);
    tick();
    set_in(1'b0, 1'b1, r1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4180 || id_instr !== r1)
      $display("FAIL hold_pre got %h/%h/%h want 1/4180/%h", id_valid, id_pc, id_instr, r1); else n_pass++;
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4188);
    n_checks++; if (pc_advance !== 1'b1) $display("FAIL hold_issue_under_stall got %h want 1", pc_advance); else n_pass++;
    tick();
    set_in(1'b1, 1'b1, 32'h2402_0005, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_instr !== r1 || imem_req_valid !== 1'b0)
      $display("FAIL hold_stall1 got %h/%h req=%h want 1/%h/0", id_valid, id_instr, imem_req_valid, r1); else n_pass++;
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_instr !== r1 || imem_req_valid !== 1'b0)
      $display("FAIL hold_stall2 got %h/%h req=%h want 1/%h/0", id_valid, id_instr, imem_req_valid, r1); else n_pass++;
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL hold_no_req got %h want 0", imem_req_valid); else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_instr !== 32'h2402_0005 || id_pc !== 32'h4184)
      $display("FAIL hold_release got %h/%h/%h want 1/24020005/4184", id_valid, id_instr, id_pc); else n_pass++;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4188) $display("FAIL hold_next_req got %h/%h want 1/4188", imem_req_valid, imem_addr); else n_pass++;
  endtask

  task automatic test_flush_req();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4180, 32'h418C);
    n_checks++; if (pc_advance !== 1'b0 || imem_req_valid !== 1'b1) $display("FAIL fr_adv got adv=%h req=%h want 0/1", pc_advance, imem_req_valid); else n_pass++;
    tick();
    n_checks++; if (pc_o !== 32'h4180 || imem_req_valid !== 1'b0 || id_valid !== 1'b0)
      $display("FAIL fr_drop got pc=%h req=%h v=%h want 4180/0/0", pc_o, imem_req_valid, id_valid); else n_pass++;
    set_in(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4180)
      $display("FAIL fr_stale got v=%h req=%h a=%h want 0/1/4180", id_valid, imem_req_valid, imem_addr); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4184);
    tick();
    rst_n = 1'b0; model_reset(); #1;
    n_checks++; if (pc_o !== 32'h3000 || imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0)
      $display("FAIL rmw_async got pc=%h req=%h v=%h i=%h p=%h want 3000/0/0/0/0", pc_o, imem_req_valid, id_valid, id_instr, id_pc); else n_pass++;
    tick();
    rst_n = 1'b1; m_rst = 1'b0;
    set_in(1'b0, 1'b1, 32'hFEED_FACE, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h3000) $display("FAIL rmw_first_req got %h/%h want 1/3000", imem_req_valid, imem_addr); else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b0 || pc_o !== 32'h3000) $display("FAIL rmw_late_resp got v=%h pc=%h want 0/3000", id_valid, pc_o); else n_pass++;
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3004);
    n_checks++; if (pc_advance !== 1'b1 || imem_addr !== 32'h3000) $display("FAIL rmw_accept got %h/%h want 1/3000", pc_advance, imem_addr); else n_pass++;
    tick();
    set_in(1'b0, 1'b1, 32'h0123_4567, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3000 || id_instr !== 32'h0123_4567)
      $display("FAIL rmw_deliver got %h/%h/%h want 1/3000/01234567", id_valid, id_pc, id_instr); else n_pass++;
  endtask

  task automatic test_random();
    bit mem_pend;
    int mem_cnt;
    bit rdy;
    bit rv;
    bit st;
    bit fl;
    bit acc;
    mem_pend = 1'b0; mem_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = mem_pend && (mem_cnt == 0);
      st  = ($urandom_range(0, 9) < 3);
      fl  = ($urandom_range(0, 19) == 0);
      set_in(rdy, rv, $urandom, st, fl, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      acc = m_req_valid() && rdy;
      n_checks++; if (imem_req_valid !== m_req_valid() || (m_req_valid() && imem_addr !== m_pc))
        $display("FAIL rnd_req[%0d] got %h/%h want %h/%h", c, imem_req_valid, imem_addr, m_req_valid(), m_pc); else n_pass++;
      n_checks++; if (pc_advance !== (acc && !fl)) $display("FAIL rnd_adv[%0d] got %h want %h", c, pc_advance, acc && !fl); else n_pass++;
      tick();
      if (rv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (acc) begin mem_pend = 1'b1; mem_cnt = $urandom_range(0, 2); end
      n_checks++; if (pc_o !== m_pc) $display("FAIL rnd_pc[%0d] got %h want %h", c, pc_o, m_pc); else n_pass++;
      n_checks++; if (id_valid !== m_idv) $display("FAIL rnd_idv[%0d] got %h want %h", c, id_valid, m_idv); else n_pass++;
      if (m_idv) begin
        n_checks++; if (id_instr !== m_idi || id_pc !== m_idp)
          $display("FAIL rnd_id[%0d] got %h/%h want %h/%h", c, id_instr, id_pc, m_idi, m_idp); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_hold();
    test_flush_req();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
